// File: rtl/pipe_pkg.sv
// pipe_pkg: shared instruction word format for the issue stage, ALU pipeline and benches
package pipe_pkg;
    localparam int INSTR_W = 24;
    localparam int REG_W   = 4;
    localparam int FUNC_W  = 4;
    localparam int ADDR_W  = 8;
    typedef struct packed {
        logic [REG_W-1:0]  rs1;
        logic [REG_W-1:0]  rs2;
        logic [REG_W-1:0]  rd;
        logic [FUNC_W-1:0] func;
        logic [ADDR_W-1:0] addr;
    } instr_t;
endpackage

// File: rtl/pipe_fifo.sv
// pipe_fifo: power-of-two circular FIFO with occupancy count
module pipe_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic do_push, do_pop;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rp];
    always_ff @(posedge clk)
        if (do_push) mem[wp] <= din;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + AW'(1);
            if (do_pop) rp <= rp + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
endmodule

// File: rtl/pipe_issue.sv
// pipe_issue: FIFO-fed in-order issue stage; PIPE_ISSUE_HAZARD_STALL_EN enables the RAW interlock
module pipe_issue
    import pipe_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int HAZ_WINDOW = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               in_ready,
    input  logic               hold,
    output logic [REG_W-1:0]   rs1,
    output logic [REG_W-1:0]   rs2,
    output logic [REG_W-1:0]   rd,
    output logic [FUNC_W-1:0]  func,
    output logic [ADDR_W-1:0]  addr,
    output logic               issue_valid,
    output logic               stall,
    output logic [15:0]        issue_count
);
    instr_t head;
    logic full, empty, issue, hazard;
    logic [$clog2(DEPTH):0] occ_unused;
    pipe_fifo #(.WIDTH(INSTR_W), .DEPTH(DEPTH)) u_fifo (
        .clk(clk), .rst(rst), .push(in_valid), .pop(issue), .din(in_instr),
        .dout(head), .full(full), .empty(empty), .count(occ_unused)
    );
    assign in_ready = !full;
    assign issue    = !empty && !hold && !hazard;
`ifdef PIPE_ISSUE_HAZARD_STALL_EN
    // Slot 0 holds the instruction issued on the most recent edge; bubbles shift in as invalid.
    logic [REG_W-1:0] hist_rd [HAZ_WINDOW];
    logic             hist_v  [HAZ_WINDOW];
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < HAZ_WINDOW; i++)
            hazard = hazard || (hist_v[i] && (hist_rd[i] == head.rs1 || hist_rd[i] == head.rs2));
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            for (int i = 0; i < HAZ_WINDOW; i++) begin
                hist_v[i]  <= 1'b0;
                hist_rd[i] <= '0;
            end
        end else begin
            hist_v[0]  <= issue;
            hist_rd[0] <= head.rd;
            for (int i = 1; i < HAZ_WINDOW; i++) begin
                hist_v[i]  <= hist_v[i-1];
                hist_rd[i] <= hist_rd[i-1];
            end
        end
`else
    assign hazard = 1'b0;
`endif
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            {rs1, rs2, rd, func, addr} <= '0;
            issue_valid <= 1'b0;
            stall       <= 1'b0;
            issue_count <= '0;
        end else begin
            issue_valid <= issue;
            stall       <= !empty && !hold && hazard;
            if (issue) begin
                {rs1, rs2, rd, func, addr} <= head;
                issue_count <= issue_count + 16'd1;
            end
        end
endmodule

// File: tb/tb_pipe_issue.sv
// tb_pipe_issue: directed stimulus against a queue/timestamp model of the issue stage
module tb_pipe_issue;
    localparam int DEPTH = 4;
    localparam int HW    = 2;
`ifdef PIPE_ISSUE_HAZARD_STALL_EN
    localparam int EXP_GAP = 3;
    localparam int EXP_ST  = 2;
`else
    localparam int EXP_GAP = 1;
    localparam int EXP_ST  = 0;
`endif
    logic clk = 0, rst = 1, in_valid = 0, hold = 0;
    logic [23:0] in_instr = '0;
    logic in_ready, issue_valid, stall;
    logic [3:0] rs1, rs2, rd, func;
    logic [7:0] addr;
    logic [15:0] issue_count;
    int checks = 0, failures = 0, n_stall = 0, gap;

    pipe_issue #(.DEPTH(DEPTH), .HAZ_WINDOW(HW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
        .hold(hold), .rs1(rs1), .rs2(rs2), .rd(rd), .func(func), .addr(addr),
        .issue_valid(issue_valid), .stall(stall), .issue_count(issue_count)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] mk(int a, int b, int c, int d, int e);
        return {4'(a), 4'(b), 4'(c), 4'(d), 8'(e)};
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic offer(logic [23:0] w);
        in_valid = 1;
        in_instr = w;
        @(negedge clk);
    endtask

    // Model: a queue of words, plus the edge number at which each register was last a destination.
    logic [23:0] q[$];
    int last_iss[16];
    int edge_n;
    logic [23:0] exp_w;
    logic exp_valid, exp_stall;
    logic [15:0] exp_count;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            foreach (last_iss[r]) last_iss[r] = -1000;
            edge_n = 0;
            exp_w = '0;
            exp_valid = 0;
            exp_stall = 0;
            exp_count = '0;
        end else begin
            logic [23:0] h;
            logic hz, iss;
            edge_n++;
            h = (q.size() > 0) ? q[0] : '0;
            hz = 0;
`ifdef PIPE_ISSUE_HAZARD_STALL_EN
            if (q.size() > 0)
                hz = (edge_n - last_iss[h[23:20]] <= HW) || (edge_n - last_iss[h[19:16]] <= HW);
`endif
            iss = q.size() > 0 && !hold && !hz;
            exp_stall = q.size() > 0 && !hold && hz;
            if (in_valid && q.size() < DEPTH) q.push_back(in_instr);
            if (iss) begin
                void'(q.pop_front());
                exp_w = h;
                last_iss[h[15:12]] = edge_n;
                exp_count++;
            end
            exp_valid = iss;
        end
    end

    always @(posedge clk) begin
        #1;
        chk("in_ready", in_ready, q.size() < DEPTH);
        chk("issue_valid", issue_valid, exp_valid);
        chk("stall", stall, exp_stall);
        chk("fields", {rs1, rs2, rd, func, addr}, exp_w);
        chk("issue_count", issue_count, exp_count);
        if (stall) n_stall++;
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_ready", in_ready, 1);
        chk("rst_count", issue_count, 0);
        chk("rst_valid", issue_valid, 0);
        chk("rst_fields", {rs1, rs2, rd, func, addr}, 0);
        rst = 0;
        @(negedge clk);

        // back-to-back independent
        n_stall = 0;
        offer(mk(10, 5, 10, 5, 125));
        offer(mk(12, 8, 12, 5, 126));
        in_valid = 0;
        chk("b2b_first_valid", issue_valid, 1);
        chk("b2b_first_rd", rd, 10);
        chk("b2b_first_addr", addr, 125);
        @(negedge clk);
        chk("b2b_second_valid", issue_valid, 1);
        chk("b2b_second_rd", rd, 12);
        chk("b2b_second_addr", addr, 126);
        chk("b2b_count", issue_count, 2);
        chk("b2b_stalls", n_stall, 0);
        repeat (3) @(negedge clk);

        // RAW hazard on rs1
        n_stall = 0;
        offer(mk(10, 5, 10, 5, 125));
        offer(mk(10, 3, 4, 0, 128));
        in_valid = 0;
        chk("raw_first_rd", rd, 10);
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (!(issue_valid && rd == 4) && gap < 10);
        chk("raw_gap", gap, EXP_GAP);
        chk("raw_stalls", n_stall, EXP_ST);
        chk("raw_count", issue_count, 4);
        repeat (3) @(negedge clk);

        // full FIFO under hold
        hold = 1;
        offer(mk(1, 2, 3, 0, 1));
        offer(mk(4, 5, 6, 1, 2));
        offer(mk(7, 8, 9, 2, 3));
        offer(mk(10, 11, 12, 3, 4));
        chk("full_ready", in_ready, 0);
        offer(mk(13, 14, 15, 4, 5));
        chk("full_held_ready", in_ready, 0);
        hold = 0;
        @(negedge clk);
        chk("full_pop_valid", issue_valid, 1);
        chk("full_pop_rd", rd, 3);
        chk("full_pop_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 0;
        repeat (6) @(negedge clk);
        chk("full_count", issue_count, 9);
        chk("full_last_rd", rd, 15);

        // reset mid-stream
        hold = 1;
        offer(mk(1, 1, 1, 1, 1));
        offer(mk(2, 2, 2, 2, 2));
        offer(mk(3, 3, 3, 3, 3));
        in_valid = 0;
        rst = 1;
        #2;
        chk("mid_rst_count", issue_count, 0);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_valid", issue_valid, 0);
        chk("mid_rst_stall", stall, 0);
        chk("mid_rst_fields", {rs1, rs2, rd, func, addr}, 0);
        @(negedge clk);
        rst = 0;
        hold = 0;
        offer(mk(7, 3, 13, 11, 127));
        in_valid = 0;
        @(negedge clk);
        chk("post_rst_valid", issue_valid, 1);
        chk("post_rst_fields", {rs1, rs2, rd, func, addr}, 24'h73DB7F);
        chk("post_rst_count", issue_count, 1);
        repeat (2) @(negedge clk);

        // issue_count wrap
        hold = 1;
        force dut.issue_count = 16'hFFFF;
        exp_count = 16'hFFFF;
        #1;
        release dut.issue_count;
        offer(mk(1, 2, 3, 4, 5));
        in_valid = 0;
        hold = 0;
        @(negedge clk);
        chk("wrap_valid", issue_valid, 1);
        chk("wrap_count", issue_count, 0);
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
